stage_execute: RTL and testbench
================================

STAGE_EXECUTE -- requirements
Module: stage_execute

Interface
REQ-001 Parameter: depth, default 2048, main-memory word count; generated addresses are reduced modulo depth (power of two).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  decode stage presents an instruction this cycle.
REQ-005 flush  input  1  kill the in-flight instruction or multiply.
REQ-006 instr_type_in  input  5  instruction type from decode.
REQ-007 decode_ireg_out  input  32  raw instruction word from decode.
REQ-008 operand_a  input  32  first source value, already forwarded.
REQ-009 operand_b  input  32  second source value, already forwarded; also store data.
REQ-010 imm  input  32  sign-extended immediate.
REQ-011 stall  output  1  high while a multiply is iterating; decode holds its inputs.
REQ-012 current_instr_type  output  5  registered type for the memory stage.
REQ-013 alu_result  output  32  registered execute result.
REQ-014 memory_read_address  output  32  registered load address.
REQ-015 memory_write_address  output  32  registered store address.
REQ-016 memory_write_data  output  32  registered store data.
REQ-017 execute_ireg_out  output  32  registered instruction word for the memory stage.

Function
REQ-018 Type encoding: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 LOAD, 9 STORE, 10 MUL; codes 11-31 are treated as NOP.
REQ-019 Bubble: all registered outputs are 0; the type is NOP.
REQ-020 FSM states: IDLE and MUL_BUSY; stall = (state == MUL_BUSY), combinational from state only.
REQ-021 IDLE, in_valid=1, non-MUL type: outputs load at the next edge (latency 1).
  - current_instr_type = type; execute_ireg_out = decode_ireg_out.
  - alu_result = operation result.
REQ-022 Arithmetic is modulo 2^32.
  - ADD = a+b; SUB = a-b.
  - SLL/SRL shift a by b[4:0], logical.
  - AND/OR/XOR are bitwise.
REQ-023 LOAD: alu_result = memory_read_address = (a+imm) mod depth; memory_write_address = 0; memory_write_data = 0.
REQ-024 STORE: alu_result = memory_write_address = (a+imm) mod depth; memory_write_data = b; memory_read_address = 0.
REQ-025 Non-LOAD/STORE types drive both addresses and memory_write_data to 0.
REQ-026 IDLE, in_valid=0: bubble at the next edge.
REQ-027 MUL acceptance: IDLE, in_valid=1, type MUL at edge E0.
  - Latch a, b, type and ireg word; clear the accumulator and the 5-bit counter.
  - Enter MUL_BUSY; outputs load a bubble.
REQ-028 MUL_BUSY: one shift-add step per edge (unsigned; low 32 bits of the product kept); inputs are ignored.
REQ-029 At the edge where counter = 31 (E32):
  - Outputs load the MUL result: alu_result = product[31:0]; type MUL; latched ireg word.
  - FSM returns to IDLE.
  - stall is high for exactly 32 cycles, from after E0 until E32.
REQ-030 The counter wraps 31 -> 0 only on exit; no partial result is ever visible on the outputs.
REQ-031 flush at an edge: outputs load a bubble and the FSM goes to IDLE, aborting any multiply; flush has priority over in_valid and over MUL completion.
REQ-032 A new instruction presented in the cycle stall falls is accepted at that next edge (back-to-back, no dead cycle).

Reset
REQ-033 rst=1 immediately, independent of clk:
  - All outputs go to 0 and stall to 0.
  - FSM goes to IDLE; counter, accumulator and latched operands go to 0.
REQ-034 Reset mid-multiply discards the multiply; no result is emitted after reset release.
REQ-035 First edge after rst falls behaves as IDLE.

Verification
REQ-036 ADD a=7, b=0xFFFFFFFC, ireg 0x1234 -> after 1 edge alu_result=3, type=1, execute_ireg_out=0x1234, addresses 0.
REQ-037 LOAD a=0x7FF, imm=2, depth 2048 -> memory_read_address = alu_result = 1, memory_write_address = 0.
REQ-038 STORE a=0x10, imm=4, b=0xDEADBEEF -> memory_write_address=0x14, memory_write_data=0xDEADBEEF.
REQ-039 MUL a=0x10001, b=0x10001 -> stall high 32 cycles, outputs bubble throughout; at E32 alu_result=0x00020001, type=10, stall=0.
REQ-040 MUL then ADD held during stall -> ADD result appears exactly 1 edge after the MUL result.
REQ-041 MUL accepted, flush at E10 -> bubble, stall=0 next cycle; in a separate run, rst at E20 -> all outputs 0 and no result after release.

Source files
------------

// File: rtl/stage_execute.sv
// Execute stage: single-cycle ALU/address generation plus a 32-step shift-add multiplier
// that stalls decode while it iterates. All outputs are registered.
module stage_execute #(
    parameter int depth = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [4:0]  instr_type_in,
    input  logic [31:0] decode_ireg_out,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] imm,
    output logic        stall,
    output logic [4:0]  current_instr_type,
    output logic [31:0] alu_result,
    output logic [31:0] memory_read_address,
    output logic [31:0] memory_write_address,
    output logic [31:0] memory_write_data,
    output logic [31:0] execute_ireg_out
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam logic [4:0]  T_NOP   = 5'd0;
    localparam logic [4:0]  T_ADD   = 5'd1;
    localparam logic [4:0]  T_SUB   = 5'd2;
    localparam logic [4:0]  T_AND   = 5'd3;
    localparam logic [4:0]  T_OR    = 5'd4;
    localparam logic [4:0]  T_XOR   = 5'd5;
    localparam logic [4:0]  T_SLL   = 5'd6;
    localparam logic [4:0]  T_SRL   = 5'd7;
    localparam logic [4:0]  T_LOAD  = 5'd8;
    localparam logic [4:0]  T_STORE = 5'd9;
    localparam logic [4:0]  T_MUL   = 5'd10;
    localparam logic [31:0] addr_mask = 32'(depth) - 32'd1;

    state_t      state_r, state_nxt_s;
    logic [31:0] mul_a_r, mul_a_nxt_s;
    logic [31:0] mul_b_r, mul_b_nxt_s;
    logic [31:0] mul_acc_r, mul_acc_nxt_s;
    logic [31:0] mul_ireg_r, mul_ireg_nxt_s;
    logic [4:0]  mul_cnt_r, mul_cnt_nxt_s;
    logic [31:0] mul_sum_s;

    logic [4:0]  type_nxt_s;
    logic [31:0] alu_nxt_s, rd_addr_nxt_s, wr_addr_nxt_s, wr_data_nxt_s, ireg_nxt_s;

    logic [4:0]  op_type_s;
    logic [31:0] op_alu_s, op_rd_addr_s, op_wr_addr_s, op_wr_data_s, eff_addr_s;

    assign stall = (state_r == MUL_BUSY);

    // Single-cycle result for a non-multiply instruction presented by decode.
    always_comb begin
        eff_addr_s   = (operand_a + imm) & addr_mask;
        op_type_s    = instr_type_in;
        op_alu_s     = 32'd0;
        op_rd_addr_s = 32'd0;
        op_wr_addr_s = 32'd0;
        op_wr_data_s = 32'd0;
        case (instr_type_in)
            T_NOP:   op_alu_s = 32'd0;
            T_ADD:   op_alu_s = operand_a + operand_b;
            T_SUB:   op_alu_s = operand_a - operand_b;
            T_AND:   op_alu_s = operand_a & operand_b;
            T_OR:    op_alu_s = operand_a | operand_b;
            T_XOR:   op_alu_s = operand_a ^ operand_b;
            T_SLL:   op_alu_s = operand_a << operand_b[4:0];
            T_SRL:   op_alu_s = operand_a >> operand_b[4:0];
            T_LOAD: begin
                op_alu_s     = eff_addr_s;
                op_rd_addr_s = eff_addr_s;
            end
            T_STORE: begin
                op_alu_s     = eff_addr_s;
                op_wr_addr_s = eff_addr_s;
                op_wr_data_s = operand_b;
            end
            default: op_type_s = T_NOP;
        endcase
    end

    // Next-state and next-output selection; every edge loads a bubble unless a result is due.
    always_comb begin
        state_nxt_s    = state_r;
        mul_a_nxt_s    = mul_a_r;
        mul_b_nxt_s    = mul_b_r;
        mul_acc_nxt_s  = mul_acc_r;
        mul_ireg_nxt_s = mul_ireg_r;
        mul_cnt_nxt_s  = mul_cnt_r;
        type_nxt_s     = T_NOP;
        alu_nxt_s      = 32'd0;
        rd_addr_nxt_s  = 32'd0;
        wr_addr_nxt_s  = 32'd0;
        wr_data_nxt_s  = 32'd0;
        ireg_nxt_s     = 32'd0;
        // multiplicand shifts left and multiplier shifts right, so bit 0 selects each partial product
        mul_sum_s      = mul_acc_r + (mul_b_r[0] ? mul_a_r : 32'd0);

        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && (instr_type_in == T_MUL)) begin
                        state_nxt_s    = MUL_BUSY;
                        mul_a_nxt_s    = operand_a;
                        mul_b_nxt_s    = operand_b;
                        mul_acc_nxt_s  = 32'd0;
                        mul_cnt_nxt_s  = 5'd0;
                        mul_ireg_nxt_s = decode_ireg_out;
                    end else if (in_valid) begin
                        type_nxt_s    = op_type_s;
                        alu_nxt_s     = op_alu_s;
                        rd_addr_nxt_s = op_rd_addr_s;
                        wr_addr_nxt_s = op_wr_addr_s;
                        wr_data_nxt_s = op_wr_data_s;
                        ireg_nxt_s    = decode_ireg_out;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                MUL_BUSY: begin
                    mul_acc_nxt_s = mul_sum_s;
                    mul_a_nxt_s   = mul_a_r << 1;
                    mul_b_nxt_s   = mul_b_r >> 1;
                    mul_cnt_nxt_s = mul_cnt_r + 5'd1;
                    if (mul_cnt_r == 5'd31) begin
                        state_nxt_s = IDLE;
                        type_nxt_s  = T_MUL;
                        alu_nxt_s   = mul_sum_s;
                        ireg_nxt_s  = mul_ireg_r;
                    end else begin
                        state_nxt_s = MUL_BUSY;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Multiplier working registers and registered stage outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_r              <= 32'd0;
            mul_b_r              <= 32'd0;
            mul_acc_r            <= 32'd0;
            mul_ireg_r           <= 32'd0;
            mul_cnt_r            <= 5'd0;
            current_instr_type   <= 5'd0;
            alu_result           <= 32'd0;
            memory_read_address  <= 32'd0;
            memory_write_address <= 32'd0;
            memory_write_data    <= 32'd0;
            execute_ireg_out     <= 32'd0;
        end else begin
            mul_a_r              <= mul_a_nxt_s;
            mul_b_r              <= mul_b_nxt_s;
            mul_acc_r            <= mul_acc_nxt_s;
            mul_ireg_r           <= mul_ireg_nxt_s;
            mul_cnt_r            <= mul_cnt_nxt_s;
            current_instr_type   <= type_nxt_s;
            alu_result           <= alu_nxt_s;
            memory_read_address  <= rd_addr_nxt_s;
            memory_write_address <= wr_addr_nxt_s;
            memory_write_data    <= wr_data_nxt_s;
            execute_ireg_out     <= ireg_nxt_s;
        end
    end

endmodule

// File: tb/tb_stage_execute.sv
// Randomized self-checking bench for stage_execute against an arithmetic reference model.
module tb_stage_execute;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush;
    logic [4:0]  instr_type_in;
    logic [31:0] decode_ireg_out, operand_a, operand_b, imm;
    logic        stall;
    logic [4:0]  current_instr_type;
    logic [31:0] alu_result, memory_read_address, memory_write_address, memory_write_data, execute_ireg_out;

    int checks = 0;
    int errors = 0;

    stage_execute #(.depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .instr_type_in(instr_type_in), .decode_ireg_out(decode_ireg_out),
        .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
        .stall(stall), .current_instr_type(current_instr_type), .alu_result(alu_result),
        .memory_read_address(memory_read_address), .memory_write_address(memory_write_address),
        .memory_write_data(memory_write_data), .execute_ireg_out(execute_ireg_out)
    );

    always #5 clk = ~clk;

    localparam logic [165:0] BUBBLE      = 166'd0;
    localparam logic [165:0] STALL_BUBBE = {1'b1, 165'd0};

    // {stall, type, alu, read addr, write addr, write data, ireg}
    function automatic logic [165:0] observed();
        return {stall, current_instr_type, alu_result, memory_read_address,
                memory_write_address, memory_write_data, execute_ireg_out};
    endfunction

    // Expected registered outputs for one accepted instruction (MUL gives the final product).
    function automatic logic [165:0] model(input logic [4:0] t, input logic [31:0] x, y, im, iw);
        logic [31:0] r, rd, wr, wd, ea;
        logic [4:0]  to;
        r = 32'd0; rd = 32'd0; wr = 32'd0; wd = 32'd0; to = t;
        ea = x + im;
        ea = ea % 32'(DEPTH);
        case (t)
            5'd0:  r = 32'd0;
            5'd1:  r = x + y;
            5'd2:  r = x - y;
            5'd3:  r = x & y;
            5'd4:  r = x | y;
            5'd5:  r = x ^ y;
            5'd6:  r = x << y[4:0];
            5'd7:  r = x >> y[4:0];
            5'd8:  begin rd = ea; r = ea; end
            5'd9:  begin wr = ea; r = ea; wd = y; end
            5'd10: r = x * y;
            default: to = 5'd0;
        endcase
        return {1'b0, to, r, rd, wr, wd, iw};
    endfunction

    task automatic drive(input logic v, input logic [4:0] t, input logic [31:0] x, y, im, iw);
        in_valid = v; instr_type_in = t; operand_a = x; operand_b = y; imm = im; decode_ireg_out = iw;
    endtask

    task automatic drive_junk();
        drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (observed() !== BUBBLE) begin
            errors++; $display("FAIL reset_async got %h exp %h", observed(), BUBBLE);
        end
        drive(1'b1, 5'd1, 32'd5, 32'd6, 32'd0, 32'hAAAA);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (observed() !== BUBBLE) begin
                errors++; $display("FAIL reset_hold got %h exp %h", observed(), BUBBLE);
            end
        end
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_directed();
        logic [165:0] e;
        drive(1'b1, 5'd1, 32'd7, 32'hFFFF_FFFC, 32'd0, 32'h1234);
        tick();
        e = {1'b0, 5'd1, 32'd3, 32'd0, 32'd0, 32'd0, 32'h1234};
        checks++;
        if (observed() !== e) begin errors++; $display("FAIL add_dir got %h exp %h", observed(), e); end
        drive(1'b1, 5'd8, 32'h7FF, 32'h55, 32'd2, 32'h8888);
        tick();
        e = {1'b0, 5'd8, 32'd1, 32'd1, 32'd0, 32'd0, 32'h8888};
        checks++;
        if (observed() !== e) begin errors++; $display("FAIL load_wrap got %h exp %h", observed(), e); end
        drive(1'b1, 5'd9, 32'h10, 32'hDEAD_BEEF, 32'd4, 32'h9999);
        tick();
        e = {1'b0, 5'd9, 32'h14, 32'd0, 32'h14, 32'hDEAD_BEEF, 32'h9999};
        checks++;
        if (observed() !== e) begin errors++; $display("FAIL store_dir got %h exp %h", observed(), e); end
        drive(1'b0, 5'd1, 32'd1, 32'd1, 32'd0, 32'h1);
        tick();
        checks++;
        if (observed() !== BUBBLE) begin errors++; $display("FAIL idle_bubble got %h exp %h", observed(), BUBBLE); end
    endtask

    task automatic test_random_alu();
        logic        v;
        logic [4:0]  t;
        logic [31:0] x, y, im, iw;
        logic [165:0] e;
        for (int i = 0; i < 80; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            t = 5'($urandom_range(0, 31));
            if (t == 5'd10) t = 5'd1;
            x = $urandom; y = $urandom; im = $urandom; iw = $urandom;
            drive(v, t, x, y, im, iw);
            tick();
            e = v ? model(t, x, y, im, iw) : BUBBLE;
            checks++;
            if (v && t > 5'd10) begin
                if (observed() >> 32 !== e >> 32) begin
                    errors++; $display("FAIL rand_nop_code got %h exp %h", observed(), e);
                end
            end else if (observed() !== e) begin
                errors++; $display("FAIL rand_alu t=%0d got %h exp %h", t, observed(), e);
            end
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic run_mul(input logic [31:0] x, y);
        logic [31:0]  iw;
        logic [165:0] e;
        iw = $urandom;
        drive(1'b1, 5'd10, x, y, $urandom, iw);
        tick();
        checks++;
        if (observed() !== STALL_BUBBE) begin errors++; $display("FAIL mul_accept got %h exp %h", observed(), STALL_BUBBE); end
        for (int i = 1; i <= 32; i++) begin
            drive_junk();
            tick();
            checks++;
            if (i < 32) begin
                if (observed() !== STALL_BUBBE) begin
                    errors++; $display("FAIL mul_busy cyc=%0d got %h exp %h", i, observed(), STALL_BUBBE);
                end
            end else begin
                e = model(5'd10, x, y, 32'd0, iw);
                if (observed() !== e) begin errors++; $display("FAIL mul_result got %h exp %h", observed(), e); end
            end
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_mul();
        run_mul(32'h0001_0001, 32'h0001_0001);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) run_mul($urandom, $urandom);
    endtask

    task automatic test_back_to_back();
        logic [31:0]  x, y, p, q;
        logic [165:0] e;
        x = $urandom; y = $urandom; p = $urandom; q = $urandom;
        drive(1'b1, 5'd10, x, y, 32'd0, 32'h0000_0A0A);
        tick();
        drive(1'b1, 5'd1, p, q, 32'd0, 32'h0000_0B0B);
        for (int i = 1; i <= 32; i++) tick();
        e = model(5'd10, x, y, 32'd0, 32'h0000_0A0A);
        checks++;
        if (observed() !== e) begin errors++; $display("FAIL b2b_mul got %h exp %h", observed(), e); end
        tick();
        e = model(5'd1, p, q, 32'd0, 32'h0000_0B0B);
        checks++;
        if (observed() !== e) begin errors++; $display("FAIL b2b_add got %h exp %h", observed(), e); end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        checks++;
        if (observed() !== BUBBLE) begin errors++; $display("FAIL b2b_idle got %h exp %h", observed(), BUBBLE); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(1'b1, 5'd1, 32'd3, 32'd4, 32'd0, 32'h77);
        tick();
        checks++;
        if (observed() !== BUBBLE) begin errors++; $display("FAIL flush_idle got %h exp %h", observed(), BUBBLE); end
        flush = 1'b0;
        // abort at E10 and at the completion edge E32
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 5'd10, 32'h0001_0001, 32'h0001_0001, 32'd0, 32'h55);
            tick();
            for (int i = 1; i < (k == 0 ? 10 : 32); i++) begin
                drive_junk();
                tick();
            end
            flush = 1'b1;
            drive(1'b1, 5'd1, 32'd1, 32'd2, 32'd0, 32'h66);
            tick();
            checks++;
            if (observed() !== BUBBLE) begin errors++; $display("FAIL flush_mul k=%0d got %h exp %h", k, observed(), BUBBLE); end
            flush = 1'b0;
            drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            for (int i = 0; i < 34; i++) begin
                tick();
                checks++;
                if (observed() !== BUBBLE) begin errors++; $display("FAIL flush_after k=%0d got %h exp %h", k, observed(), BUBBLE); end
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [165:0] e;
        drive(1'b1, 5'd10, 32'h0001_0001, 32'h0001_0001, 32'd0, 32'h42);
        tick();
        for (int i = 1; i < 20; i++) begin
            drive_junk();
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (observed() !== BUBBLE) begin errors++; $display("FAIL rst_mid_async got %h exp %h", observed(), BUBBLE); end
        tick();
        tick();
        rst = 1'b0;
        drive(1'b1, 5'd2, 32'd10, 32'd3, 32'd0, 32'h31);
        tick();
        e = model(5'd2, 32'd10, 32'd3, 32'd0, 32'h31);
        checks++;
        if (observed() !== e) begin errors++; $display("FAIL rst_first_edge got %h exp %h", observed(), e); end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 36; i++) begin
            tick();
            checks++;
            if (observed() !== BUBBLE) begin errors++; $display("FAIL rst_no_result got %h exp %h", observed(), BUBBLE); end
        end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #2;
        test_reset();
        test_directed();
        test_random_alu();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
